// File: rtl/pinaipple_bus_pkg.sv
// Shared bus types and helpers for the pinaipple memory interconnect.
// rr_next is kept here so later arbiters pick requesters the same way.
package pinaipple_bus_pkg;

  localparam int BusAddrWidth = 32;
  localparam int BusDataWidth = 32;
  localparam int BusBeWidth   = BusDataWidth / 8;
  localparam int RrMaxReq     = 32;
  localparam int RrIdxW       = $clog2(RrMaxReq);

  typedef struct packed {
    logic [BusAddrWidth-1:0] addr;
    logic                    we;
    logic [BusBeWidth-1:0]   be;
    logic [BusDataWidth-1:0] wdata;
  } bus_req_t;

  // Scans last+1, last+2, ... (mod num_req); nearest asserted request wins, 0 if none
  function automatic int rr_next(input int last, input logic [RrMaxReq-1:0] req,
                                 input int num_req);
    int result;
    int idx;
    result = 0;
    for (int k = num_req; k > 0; k--) begin
      idx = (last + k) % num_req;
      if (req[idx[RrIdxW-1:0]]) result = idx;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// Flop-based in-order FIFO holding the requester index of every accepted request.
module tag_fifo #(
  parameter int Width = 1,
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr;
  logic [PtrW-1:0]  rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointers wrap explicitly so non-power-of-2 depths work
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + 1'b1;
      end
      if (do_pop) rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one ibex-style memory port; responses are routed back
// to their issuer through an in-order tag FIFO.
module mem_port_arbiter
  import pinaipple_bus_pkg::*;
#(
  parameter int NumReq         = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  localparam int BeWidth = DataWidth / 8,
  localparam int LastW   = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntW    = $clog2(MaxOutstanding + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  req_i,
  output logic [NumReq-1:0]                  gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0]                  we_i,
  input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
  output logic [NumReq-1:0]                  rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]   rdata_o,
  output logic                               mem_req_o,
  input  logic                               mem_gnt_i,
  output logic                               mem_we_o,
  output logic [BeWidth-1:0]                 mem_be_o,
  output logic [AddrWidth-1:0]               mem_addr_o,
  output logic [DataWidth-1:0]               mem_wdata_o,
  input  logic                               mem_rvalid_i,
  input  logic [DataWidth-1:0]               mem_rdata_i,
  output logic                               busy_o,
  output logic                               err_o
);

  logic [LastW-1:0]    last;
  logic [LastW-1:0]    sel;
  logic [LastW-1:0]    mux_idx;
  logic [LastW-1:0]    head_tag;
  logic [RrMaxReq-1:0] req_ext;
  logic [CntW-1:0]     count;
  logic                full;
  logic                empty;
  logic                handshake;
  logic                pop;

  always_comb begin
    req_ext              = '0;
    req_ext[NumReq-1:0]  = req_i;
    sel                  = LastW'(rr_next(int'(last), req_ext, NumReq));
  end

  // Full is taken from the registered count, so a same-cycle pop never frees a slot
  assign mem_req_o = (|req_i) && !full && !rst_i;
  assign handshake = mem_req_o && mem_gnt_i;
  assign pop       = mem_rvalid_i && !empty && !rst_i;
  assign busy_o    = (count != '0);

  assign mux_idx     = mem_req_o ? sel : '0;
  assign mem_addr_o  = addr_i[mux_idx];
  assign mem_we_o    = we_i[mux_idx];
  assign mem_be_o    = be_i[mux_idx];
  assign mem_wdata_o = wdata_i[mux_idx];

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (handshake) gnt_o[sel] = 1'b1;
    if (pop) rvalid_o[head_tag] = 1'b1;
    for (int i = 0; i < NumReq; i++) rdata_o[i] = mem_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last  <= LastW'(NumReq - 1);
      err_o <= 1'b0;
    end else begin
      if (handshake) last <= sel;
      if (mem_rvalid_i && empty) err_o <= 1'b1;
    end
  end

  tag_fifo #(
    .Width (LastW),
    .Depth (MaxOutstanding)
  ) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (handshake),
    .pop   (pop),
    .wdata (sel),
    .rdata (head_tag),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (2 requesters, 2 outstanding) with a hand-driven memory.
module tb_mem_port_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0][31:0] addr;
  logic [1:0]       we;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] wdata;
  logic [1:0]       rvalid;
  logic [1:0][31:0] rdata;
  logic             memReq;
  logic             memGnt;
  logic             memWe;
  logic [3:0]       memBe;
  logic [31:0]      memAddr;
  logic [31:0]      memWdata;
  logic             memRvalid;
  logic [31:0]      memRdata;
  logic             busy;
  logic             err;

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(
    .NumReq         (2),
    .AddrWidth      (32),
    .DataWidth      (32),
    .MaxOutstanding (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .gnt_o        (gnt),
    .addr_i       (addr),
    .we_i         (we),
    .be_i         (be),
    .wdata_i      (wdata),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .mem_req_o    (memReq),
    .mem_gnt_i    (memGnt),
    .mem_we_o     (memWe),
    .mem_be_o     (memBe),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_rvalid_i (memRvalid),
    .mem_rdata_i  (memRdata),
    .busy_o       (busy),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic mg,
                               input logic mrv, input logic [31:0] mrd);
    @(negedge clk);
    rst       = r;
    req       = rq;
    memGnt    = mg;
    memRvalid = mrv;
    memRdata  = mrd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [1:0] expG;
    logic [1:0] prevG;

    addr      = {32'h0000_0200, 32'h0000_0100};
    we        = 2'b10;
    be        = {4'h3, 4'hF};
    wdata     = {32'h2222_2222, 32'h1111_1111};
    rst       = 1'b1;
    req       = 2'b00;
    memGnt    = 1'b0;
    memRvalid = 1'b0;
    memRdata  = '0;

    // Reset with live requests and a stray response: outputs forced low
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1, 32'h0);
    checkOutput("rst_gnt", gnt, 2'b00);
    checkOutput("rst_mem_req", memReq, 1'b0);
    checkOutput("rst_rvalid", rvalid, 2'b00);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_err", err, 1'b0);
    checkOutput("idle_mem_req", memReq, 1'b0);
    checkOutput("idle_addr_from_req0", memAddr, 32'h100);

    // Fairness: both requesting, 1-cycle memory answers each grant next cycle
    prevG = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, (k <= 6) ? 2'b11 : 2'b00, 1'b1, k >= 2, 32'hA0 + k);
      expG = (k > 6) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      checkOutput($sformatf("fair_gnt_%0d", k), gnt, expG);
      checkOutput($sformatf("fair_rvalid_%0d", k), rvalid, prevG);
      checkOutput($sformatf("fair_busy_%0d", k), busy, k >= 2);
      if (expG == 2'b10) begin
        checkOutput($sformatf("fair_addr_%0d", k), memAddr, 32'h200);
        checkOutput($sformatf("fair_we_%0d", k), memWe, 1'b1);
        checkOutput($sformatf("fair_be_%0d", k), memBe, 4'h3);
        checkOutput($sformatf("fair_wdata_%0d", k), memWdata, 32'h2222_2222);
      end
      if (k >= 2) checkOutput($sformatf("fair_rdata1_%0d", k), rdata[1], 32'hA0 + k);
      prevG = expG;
    end
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("fair_drained_busy", busy, 1'b0);

    // Single requester read at 0x100
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b0, 32'h0);
    checkOutput("single_gnt", gnt, 2'b01);
    checkOutput("single_addr", memAddr, 32'h100);
    checkOutput("single_we", memWe, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF);
    checkOutput("single_rvalid", rvalid, 2'b01);
    checkOutput("single_rdata0", rdata[0], 32'hDEAD_BEEF);
    checkOutput("single_busy_before_pop", busy, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("single_busy_after", busy, 1'b0);

    // Stall: last points at 0, so req1 is selected and must stay selected while unGranted
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("stall_gnt_%0d", k), gnt, 2'b00);
      checkOutput($sformatf("stall_mem_req_%0d", k), memReq, 1'b1);
      checkOutput($sformatf("stall_addr_%0d", k), memAddr, 32'h200);
    end
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 32'h0);
    checkOutput("stall_release_gnt", gnt, 2'b10);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'h5);
    checkOutput("stall_rvalid", rvalid, 2'b10);

    // Backpressure: no responses, only two grants fit
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_gnt_1", gnt, 2'b01);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_gnt_2", gnt, 2'b10);
    for (int k = 3; k <= 4; k++) begin
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("bp_full_gnt_%0d", k), gnt, 2'b00);
      checkOutput($sformatf("bp_full_mem_req_%0d", k), memReq, 1'b0);
    end
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b1, 32'h1);
    checkOutput("bp_pop_rvalid", rvalid, 2'b01);
    checkOutput("bp_pop_cycle_gnt", gnt, 2'b00);
    checkOutput("bp_pop_cycle_mem_req", memReq, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_refill_gnt", gnt, 2'b01);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'h2);
    checkOutput("bp_drain_rvalid_1", rvalid, 2'b10);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'h3);
    checkOutput("bp_drain_rvalid_2", rvalid, 2'b01);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_drained_busy", busy, 1'b0);
    checkOutput("bp_no_err", err, 1'b0);

    // Spurious response with nothing outstanding
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'h0);
    checkOutput("spur_rvalid", rvalid, 2'b00);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("spur_err_set", err, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("spur_err_held", err, 1'b1);

    // Reset with two requests outstanding
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_gnt_1", gnt, 2'b10);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_gnt_2", gnt, 2'b01);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_rst_gnt", gnt, 2'b00);
    checkOutput("mid_rst_mem_req", memReq, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_after_busy", busy, 1'b0);
    checkOutput("mid_after_err_cleared", err, 1'b0);
    checkOutput("mid_after_first_gnt", gnt, 2'b01);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'h7);
    checkOutput("mid_after_rvalid", rvalid, 2'b01);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 32'h8);
    checkOutput("mid_stale_rvalid", rvalid, 2'b00);
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_stale_err", err, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
